// File: rtl/fix_msg_receiver.sv
`default_nettype none
// ============================================================================
// Module      : fix_msg_receiver
// Description : Byte-serial FIX message parser. Splits the incoming stream
//               into tag=value fields, streams value bytes out, captures the
//               MsgType (tag 35) and verifies the trailing CheckSum (tag 10)
//               against an 8-bit running sum of the message bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module fix_msg_receiver #(
    parameter int MAX_TAG_DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  message_i,
    input  logic        new_message_i,
    input  logic        end_session_i,
    output logic [13:0] tag_o,
    output logic        val_valid_o,
    output logic [7:0]  val_byte_o,
    output logic        field_end_o,
    output logic [7:0]  msg_type_o,
    output logic        msg_done_o,
    output logic        chk_ok_o,
    output logic        err_o
);

    localparam int c_CNT_W = $clog2(MAX_TAG_DIGITS + 1);

    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_TAG_DIGITS);
    localparam logic [7:0]         c_SOH     = 8'h01;
    localparam logic [7:0]         c_EQ      = 8'h3D;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_TAG       = 3'd1;
    localparam logic [2:0] c_VALUE     = 3'd2;
    localparam logic [2:0] c_CHK_VALUE = 3'd3;
    localparam logic [2:0] c_SKIP      = 3'd4;

    logic [2:0]         r_state;
    logic [7:0]         r_sum;          // running sum of all consumed bytes
    logic [7:0]         r_chk_base;     // sum up to the start of the current tag
    logic [13:0]        r_tag_acc;
    logic [c_CNT_W-1:0] r_dig_cnt;
    logic               r_err_seen;
    logic               r_val_empty;    // no value byte seen yet in this field
    logic               r_is_msg_type;  // current field is tag 35
    logic [7:0]         r_chk_val;
    logic [1:0]         r_chk_cnt;

    logic [13:0]        r_tag;
    logic               r_val_valid;
    logic [7:0]         r_val_byte;
    logic               r_field_end;
    logic [7:0]         r_msg_type;
    logic               r_msg_done;
    logic               r_chk_ok;
    logic               r_err;

    logic               w_is_digit;
    logic [3:0]         w_digit;
    logic [13:0]        w_tag_next;
    logic [11:0]        w_chk_next;
    logic [7:0]         w_sum_next;

    // Byte classification and next-value arithmetic for the accumulators
    always_comb begin
        w_is_digit = (message_i >= 8'h30) && (message_i <= 8'h39);
        w_digit    = message_i[3:0];
        w_tag_next = (r_tag_acc * 14'd10) + {10'd0, w_digit};
        w_chk_next = ({4'd0, r_chk_val} * 12'd10) + {8'd0, w_digit};
        w_sum_next = r_sum + message_i;
    end

    // Parser state machine; all outputs are registered, pulses default low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_IDLE;
            r_sum         <= 8'd0;
            r_chk_base    <= 8'd0;
            r_tag_acc     <= 14'd0;
            r_dig_cnt     <= '0;
            r_err_seen    <= 1'b0;
            r_val_empty   <= 1'b0;
            r_is_msg_type <= 1'b0;
            r_chk_val     <= 8'd0;
            r_chk_cnt     <= 2'd0;
            r_tag         <= 14'd0;
            r_val_valid   <= 1'b0;
            r_val_byte    <= 8'd0;
            r_field_end   <= 1'b0;
            r_msg_type    <= 8'd0;
            r_msg_done    <= 1'b0;
            r_chk_ok      <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_val_valid <= 1'b0;
            r_field_end <= 1'b0;
            r_msg_done  <= 1'b0;
            r_chk_ok    <= 1'b0;
            r_err       <= 1'b0;
            if (end_session_i) begin
                // Abort wins over a strobe in the same cycle; the byte is dropped
                r_state <= c_IDLE;
            end else if (new_message_i) begin
                r_sum <= w_sum_next;
                case (r_state)
                    c_IDLE: begin
                        // Message start: sum restarts with this byte
                        r_sum      <= message_i;
                        r_chk_base <= 8'd0;
                        r_err_seen <= 1'b0;
                        r_msg_type <= 8'd0;
                        if (w_is_digit) begin
                            r_tag_acc <= {10'd0, w_digit};
                            r_dig_cnt <= c_CNT_W'(1);
                            r_state   <= c_TAG;
                        end else begin
                            r_tag_acc  <= 14'd0;
                            r_dig_cnt  <= '0;
                            r_err      <= 1'b1;
                            r_err_seen <= 1'b1;
                            r_state    <= c_SKIP;
                        end
                    end
                    c_TAG: begin
                        // Sum before the first tag byte is what a tag-10 field checks
                        if (r_dig_cnt == '0) begin
                            r_chk_base <= r_sum;
                        end
                        if (w_is_digit && (r_dig_cnt != c_MAX_CNT)) begin
                            r_tag_acc <= w_tag_next;
                            r_dig_cnt <= r_dig_cnt + c_CNT_W'(1);
                        end else if ((message_i == c_EQ) && (r_dig_cnt != '0)) begin
                            r_tag         <= r_tag_acc;
                            r_val_empty   <= 1'b1;
                            r_is_msg_type <= (r_tag_acc == 14'd35);
                            r_chk_val     <= 8'd0;
                            r_chk_cnt     <= 2'd0;
                            r_state       <= (r_tag_acc == 14'd10) ? c_CHK_VALUE : c_VALUE;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_seen <= 1'b1;
                            r_state    <= c_SKIP;
                        end
                    end
                    c_VALUE: begin
                        if (message_i == c_SOH) begin
                            r_tag_acc <= 14'd0;
                            r_dig_cnt <= '0;
                            r_state   <= c_TAG;
                            if (r_val_empty) begin
                                r_err      <= 1'b1;
                                r_err_seen <= 1'b1;
                            end else begin
                                r_field_end <= 1'b1;
                            end
                        end else begin
                            r_val_valid <= 1'b1;
                            r_val_byte  <= message_i;
                            r_val_empty <= 1'b0;
                            if (r_is_msg_type && r_val_empty) begin
                                r_msg_type <= message_i;
                            end
                        end
                    end
                    c_CHK_VALUE: begin
                        if (r_chk_cnt == 2'd3) begin
                            if (message_i == c_SOH) begin
                                r_msg_done  <= 1'b1;
                                r_field_end <= 1'b1;
                                r_chk_ok    <= (r_chk_val == r_chk_base) && !r_err_seen;
                                r_state     <= c_IDLE;
                            end else begin
                                r_err      <= 1'b1;
                                r_err_seen <= 1'b1;
                                r_state    <= c_SKIP;
                            end
                        end else if (w_is_digit && (w_chk_next <= 12'd255)) begin
                            r_chk_val <= w_chk_next[7:0];
                            r_chk_cnt <= r_chk_cnt + 2'd1;
                        end else begin
                            // Non-digit or a three-digit value that does not fit a byte
                            r_err      <= 1'b1;
                            r_err_seen <= 1'b1;
                            r_state    <= c_SKIP;
                        end
                    end
                    c_SKIP: begin
                        if (message_i == c_SOH) begin
                            r_tag_acc <= 14'd0;
                            r_dig_cnt <= '0;
                            r_state   <= c_TAG;
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

    assign tag_o       = r_tag;
    assign val_valid_o = r_val_valid;
    assign val_byte_o  = r_val_byte;
    assign field_end_o = r_field_end;
    assign msg_type_o  = r_msg_type;
    assign msg_done_o  = r_msg_done;
    assign chk_ok_o    = r_chk_ok;
    assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fix_msg_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_fix_msg_receiver
// Description : Directed bench for fix_msg_receiver. A field-level reference
//               parser turns each byte stream into an ordered list of expected
//               output events (with the byte that causes each); a compare
//               process matches every DUT pulse against that list.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fix_msg_receiver;

    localparam int MAX_TAG_DIGITS = 4;
    localparam int K_VAL   = 0;
    localparam int K_FIELD = 1;
    localparam int K_DONE  = 2;
    localparam int K_ERR   = 3;

    typedef struct {
        int         kind;
        int         idx;
        int         data;
        bit         ok;
        logic [7:0] mtype;
    } ev_t;

    logic        clk           = 1'b0;
    logic        rst           = 1'b0;
    logic [7:0]  message_i     = 8'h00;
    logic        new_message_i = 1'b0;
    logic        end_session_i = 1'b0;
    logic [13:0] tag_o;
    logic        val_valid_o;
    logic [7:0]  val_byte_o;
    logic        field_end_o;
    logic [7:0]  msg_type_o;
    logic        msg_done_o;
    logic        chk_ok_o;
    logic        err_o;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc      = 0;
    int  g_idx    = 0;
    ev_t exp_q[$];
    int  consume_cyc[int];
    int  obs_tags[$];
    int  obs_errs  = 0;
    int  obs_dones = 0;
    bit  last_ok   = 1'b0;

    fix_msg_receiver #(.MAX_TAG_DIGITS(MAX_TAG_DIGITS)) dut (
        .clk           (clk),
        .rst           (rst),
        .message_i     (message_i),
        .new_message_i (new_message_i),
        .end_session_i (end_session_i),
        .tag_o         (tag_o),
        .val_valid_o   (val_valid_o),
        .val_byte_o    (val_byte_o),
        .field_end_o   (field_end_o),
        .msg_type_o    (msg_type_o),
        .msg_done_o    (msg_done_o),
        .chk_ok_o      (chk_ok_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit is_dig(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic logic [7:0] sum_range(input logic [7:0] q[$], input int a, input int b);
        logic [7:0] s = 8'h00;
        for (int k = a; k < b; k++) s += q[k];
        return s;
    endfunction

    function automatic logic [3:0] kind_pat(input int kind);
        case (kind)
            K_VAL:   return 4'b0010;
            K_FIELD: return 4'b0100;
            K_DONE:  return 4'b1100;
            default: return 4'b0001;
        endcase
    endfunction

    function automatic void push_ev(input int kind, input int idx, input int data,
                                    input bit ok, input logic [7:0] mt);
        ev_t e;
        e.kind = kind; e.idx = idx; e.data = data; e.ok = ok; e.mtype = mt;
        exp_q.push_back(e);
    endfunction

    // Field-level reference parser for one stream that starts from idle
    function automatic void model_segment(input logic [7:0] q[$], input int base);
        int n, pos, mstart, j, nd, v, e, tag, val, skip_from, bad;
        bit err_seen, msg_end;
        logic [7:0] mtype, cbase;
        n = q.size();
        pos = 0;
        while (pos < n) begin
            mstart = pos; err_seen = 1'b0; mtype = 8'h00; msg_end = 1'b0;
            while (!msg_end && pos < n) begin
                cbase = sum_range(q, mstart, pos);
                skip_from = -1;
                j = pos;
                while (j < n && is_dig(q[j])) j++;
                nd = j - pos;
                if (nd > MAX_TAG_DIGITS) begin
                    push_ev(K_ERR, base + pos + MAX_TAG_DIGITS, 0, 1'b0, 8'h00);
                    err_seen = 1'b1;
                    skip_from = pos + MAX_TAG_DIGITS + 1;
                end else if (j >= n) begin
                    return;
                end else if (q[j] != 8'h3D || nd == 0) begin
                    push_ev(K_ERR, base + j, 0, 1'b0, 8'h00);
                    err_seen = 1'b1;
                    skip_from = j + 1;
                end else begin
                    tag = 0;
                    for (int k = pos; k < j; k++) tag = tag * 10 + (int'(q[k]) - 48);
                    v = j + 1;
                    if (tag == 10) begin
                        val = 0; bad = -1;
                        for (int k = 0; k < 3 && bad < 0; k++) begin
                            if (v + k >= n) return;
                            if (!is_dig(q[v+k])) bad = v + k;
                            else begin
                                val = val * 10 + (int'(q[v+k]) - 48);
                                if (val > 255) bad = v + k;
                            end
                        end
                        if (bad >= 0) begin
                            push_ev(K_ERR, base + bad, 0, 1'b0, 8'h00);
                            err_seen = 1'b1;
                            skip_from = bad + 1;
                        end else if (v + 3 >= n) begin
                            return;
                        end else if (q[v+3] != 8'h01) begin
                            push_ev(K_ERR, base + v + 3, 0, 1'b0, 8'h00);
                            err_seen = 1'b1;
                            skip_from = v + 4;
                        end else begin
                            push_ev(K_DONE, base + v + 3, 10,
                                    (val == int'(cbase)) && !err_seen, mtype);
                            pos = v + 4;
                            msg_end = 1'b1;
                        end
                    end else begin
                        e = v;
                        while (e < n && q[e] != 8'h01) e++;
                        if (e == v) begin
                            if (v >= n) return;
                            push_ev(K_ERR, base + v, 0, 1'b0, 8'h00);
                            err_seen = 1'b1;
                            pos = v + 1;
                        end else begin
                            for (int k = v; k < e; k++) push_ev(K_VAL, base + k, int'(q[k]), 1'b0, 8'h00);
                            if (tag == 35) mtype = q[v];
                            if (e >= n) return;
                            push_ev(K_FIELD, base + e, tag, 1'b0, 8'h00);
                            pos = e + 1;
                        end
                    end
                end
                if (skip_from >= 0) begin
                    e = skip_from;
                    while (e < n && q[e] != 8'h01) e++;
                    if (e >= n) return;
                    pos = e + 1;
                end
            end
        end
    endfunction

    task automatic drive(input logic [7:0] b, input bit strobe, input bit endsess);
        @(posedge clk);
        #1;
        message_i     = b;
        new_message_i = strobe;
        end_session_i = endsess;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_segment(input string s, input bit gap);
        logic [7:0] q[$];
        for (int i = 0; i < s.len(); i++) q.push_back((s[i] == 8'h7C) ? 8'h01 : 8'(s[i]));
        model_segment(q, g_idx);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i], 1'b1, 1'b0);
            consume_cyc[g_idx + i] = cyc + 1;
            if (gap) drive(8'h00, 1'b0, 1'b0);
        end
        g_idx += q.size();
    endtask

    task automatic obs_clear();
        obs_tags.delete();
        obs_errs = 0; obs_dones = 0; last_ok = 1'b0;
    endtask

    task automatic check_zero(input string name);
        check(name, {tag_o, val_valid_o, val_byte_o, field_end_o, msg_type_o,
                     msg_done_o, chk_ok_o, err_o}, 0);
    endtask

    // Match every DUT pulse against the next expected event
    always @(negedge clk) begin
        logic [3:0] pat;
        ev_t        e;
        if (rst) begin
            pat = {msg_done_o, field_end_o, val_valid_o, err_o};
            if (pat != 4'b0000) begin
                if (err_o) obs_errs++;
                if (field_end_o) obs_tags.push_back(int'(tag_o));
                if (msg_done_o) begin obs_dones++; last_ok = chk_ok_o; end
                if (exp_q.size() == 0) begin
                    check("unexpected_event", pat, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", pat, kind_pat(e.kind));
                    check("event_cycle", cyc, consume_cyc.exists(e.idx) ? consume_cyc[e.idx] : -1);
                    case (e.kind)
                        K_VAL:   check("val_byte", val_byte_o, e.data);
                        K_FIELD: check("field_tag", tag_o, e.data);
                        K_DONE: begin
                            check("done_tag", tag_o, 10);
                            check("chk_ok", chk_ok_o, e.ok);
                            check("msg_type", msg_type_o, e.mtype);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    initial begin
        string      logon;
        logic [7:0] lq[$];
        logon = "8=FIX.4.2|9=5|35=A|10=178|";

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_outputs");
        for (int i = 0; i < 19; i++) lq.push_back((logon[i] == 8'h7C) ? 8'h01 : 8'(logon[i]));
        check("model_logon_sum", sum_range(lq, 0, 19), 178);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Valid logon, every-cycle strobes
        obs_clear();
        send_segment(logon, 1'b0);
        idle(3);
        check("logon_field_count", obs_tags.size(), 4);
        if (obs_tags.size() == 4) begin
            check("logon_tag0", obs_tags[0], 8);
            check("logon_tag1", obs_tags[1], 9);
            check("logon_tag2", obs_tags[2], 35);
            check("logon_tag3", obs_tags[3], 10);
        end
        check("logon_msg_type", msg_type_o, 8'h41);
        check("logon_done_count", obs_dones, 1);
        check("logon_chk_ok", last_ok, 1);

        // Checksum off by one
        obs_clear();
        send_segment("8=FIX.4.2|9=5|35=A|10=179|", 1'b0);
        idle(3);
        check("badsum_done_count", obs_dones, 1);
        check("badsum_chk_ok", last_ok, 0);
        check("badsum_err_count", obs_errs, 0);

        // Over-long tag, checksum otherwise correct
        obs_clear();
        send_segment("8=FIX.4.2|9=5|35=A|12345=x|10=103|", 1'b0);
        idle(3);
        check("longtag_err_count", obs_errs, 1);
        check("longtag_done_count", obs_dones, 1);
        check("longtag_chk_ok", last_ok, 0);

        // Strobe every other cycle
        obs_clear();
        send_segment(logon, 1'b1);
        idle(3);
        check("gapped_done_count", obs_dones, 1);
        check("gapped_chk_ok", last_ok, 1);

        // End of session inside the MsgType value, then a full message
        obs_clear();
        send_segment("8=FIX.4.2|9=5|35=", 1'b0);
        drive(8'h41, 1'b1, 1'b1);
        idle(2);
        check("abort_done_count", obs_dones, 0);
        send_segment(logon, 1'b0);
        idle(3);
        check("after_abort_done_count", obs_dones, 1);
        check("after_abort_chk_ok", last_ok, 1);

        // Asynchronous reset in the middle of a tag
        obs_clear();
        send_segment("8=FIX.4.2|9=5|35=A|1", 1'b0);
        idle(1);
        check("pre_reset_tag", tag_o, 35);
        check("pre_reset_msg_type", msg_type_o, 8'h41);
        #2;
        rst = 1'b0;
        #1;
        check_zero("async_reset_outputs");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        obs_clear();
        send_segment(logon, 1'b0);
        idle(3);
        check("post_reset_field_count", obs_tags.size(), 4);
        check("post_reset_done_count", obs_dones, 1);
        check("post_reset_chk_ok", last_ok, 1);

        // Assorted field errors, then a clean message back-to-back
        obs_clear();
        send_segment({"8=X|58=|A=1|10=9x|5=Q|10=2345|10=256|10=000|", logon}, 1'b0);
        idle(3);
        check("errmix_err_count", obs_errs, 5);
        check("errmix_done_count", obs_dones, 2);
        check("errmix_last_chk_ok", last_ok, 1);

        check("pending_events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fix_msg_receiver.md
FIX_MSG_RECEIVER -- requirements
Module: fix_msg_receiver

Interface
REQ-001 Parameter MAX_TAG_DIGITS, default 4, is the maximum number of decimal digits accepted in a tag.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 message_i  input  8  received byte from TOE.
REQ-005 new_message_i  input  1  byte strobe; message_i is valid in this cycle.
REQ-006 end_session_i  input  1  abort current message and return to IDLE.
REQ-007 tag_o  output  14  binary value of the current field tag.
REQ-008 val_valid_o  output  1  val_byte_o carries one value byte.
REQ-009 val_byte_o  output  8  value byte of the current field (SOH excluded).
REQ-010 field_end_o  output  1  one-cycle pulse: current field complete; tag_o is valid.
REQ-011 msg_type_o  output  8  first value byte of tag 35, held until the next message.
REQ-012 msg_done_o  output  1  one-cycle pulse: checksum field terminated.
REQ-013 chk_ok_o  output  1  qualifies msg_done_o: received checksum equals computed checksum and no field error occurred.
REQ-014 err_o  output  1  one-cycle pulse on each syntax error.

Function
REQ-015 A byte is consumed only in a cycle with new_message_i=1; otherwise all state is held.
REQ-016 States SHALL be IDLE, TAG, VALUE, CHK_VALUE and SKIP.
REQ-017 IDLE: first consumed byte clears sum, err_seen and tag accumulator, loads the byte as the first tag character, and moves to TAG.
REQ-018 TAG, digit byte ('0'..'9'): tag = tag*10 + digit; digit count increments.
REQ-019 TAG, '=' (0x3D) with digit count 1..MAX_TAG_DIGITS: move to CHK_VALUE if tag==10, else to VALUE; tag_o is updated.
REQ-020 TAG, any other byte, '=' with zero digits, or digit count exceeding MAX_TAG_DIGITS: pulse err_o, set err_seen, and go to SKIP.
REQ-021 VALUE, non-SOH byte: emit it on val_byte_o with val_valid_o=1 in the following cycle (1-cycle latency).
REQ-022 VALUE, SOH (0x01): pulse field_end_o in the following cycle; clear the tag accumulator; go to TAG.
REQ-023 VALUE, SOH as the first value byte (empty value): pulse err_o, set err_seen, and go to TAG.
REQ-024 When tag==35, capture the first value byte into msg_type_o.
REQ-025 SKIP: discard bytes until SOH, then go to TAG; no val_valid_o is asserted in SKIP.
REQ-026 Checksum: an 8-bit wrapping sum of every consumed byte from message start through the SOH preceding the "10=" tag, latched as chk_base at the first byte of each tag.
REQ-027 CHK_VALUE: accept exactly 3 decimal digits into an 8-bit value (digits forming a value >255 count as an error); the 4th byte must be SOH.
REQ-028 On the CHK_VALUE terminating SOH: in the next cycle pulse msg_done_o and field_end_o, with chk_ok_o = (received==chk_base) AND NOT err_seen; then go to IDLE.
REQ-029 CHK_VALUE, a non-digit before the 3rd digit or a non-SOH 4th byte: pulse err_o, then go to SKIP; the message completes only at a valid tag-10 field.
REQ-030 end_session_i=1 has priority over new_message_i: the byte in that cycle is dropped, the machine goes to IDLE, and no pulse is generated.
REQ-031 Pulse outputs (val_valid_o, field_end_o, msg_done_o, err_o) are high for exactly one cycle per event.
REQ-032 Back-to-back strobes on every cycle SHALL be supported with no stall and no lost byte.

Reset
REQ-033 While rst=0, all outputs SHALL be 0, the state SHALL be IDLE, and sum, chk_base, tag, err_seen and msg_type_o SHALL be cleared.
REQ-034 Reset asserted mid-message SHALL discard the partial message with no msg_done_o pulse.
REQ-035 After rst deasserts, the first strobed byte SHALL be treated as a message start.

Verification
REQ-036 Valid logon "8=FIX.4.2|9=5|35=A|10=ccc|" (| = SOH, ccc = correct sum) streamed every cycle -> 4 field_end_o pulses with tag_o=8,9,35,10; msg_type_o=0x41; msg_done_o=1 with chk_ok_o=1.
REQ-037 Same message with the checksum field incremented by 1 -> msg_done_o=1 with chk_ok_o=0, and err_o never asserted.
REQ-038 Tag "12345=x|" -> err_o pulse on the 5th digit; no val_valid_o for 'x'; next field parsed normally; final chk_ok_o=0.
REQ-039 new_message_i toggling 1/0 every other cycle over the valid message -> identical val_byte_o sequence and chk_ok_o=1.
REQ-040 end_session_i asserted during the "35=" value -> no msg_done_o; a following complete message is accepted with chk_ok_o=1.
REQ-041 rst pulsed low for 1 cycle mid-tag -> all outputs 0 immediately (asynchronous); the next message is parsed correctly.
